dpram_bank_scheduler: RTL and testbench



---
 rtl/dpram_pkg.sv | 21 ++
 rtl/dpram_bank_scheduler_if.sv | 29 ++
 rtl/dpram_rr_arb2.sv | 35 +++
 rtl/dpram_bank_scheduler.sv | 79 +++++++
 tb/tb_dpram_bank_scheduler.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared widths, bank-index helper and RAM request type
package dpram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int NUM_BANKS  = 4;
  localparam int CNT_WIDTH  = 16;
  localparam int BANK_SEL_W = $clog2(NUM_BANKS);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } mem_req_t;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  // Banks are interleaved on the top address bits.
  function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1 -: BANK_SEL_W];
  endfunction
endpackage

// File: rtl/dpram_bank_scheduler_if.sv
// rtl/dpram_bank_scheduler_if.sv - request/response streams and RAM-side port bundle
interface dpram_bank_scheduler_if;
  import dpram_pkg::*;

  logic                  a_valid, a_ready, a_we, a_rsp_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata, a_rsp_data;
  logic                  b_valid, b_ready, b_we, b_rsp_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata, b_rsp_data;

  logic                  mem_we_a, mem_we_b;
  logic [ADDR_WIDTH-1:0] mem_addr_a, mem_addr_b;
  logic [DATA_WIDTH-1:0] mem_din_a, mem_din_b, mem_dout_a, mem_dout_b;

  modport master (
    output a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata,
           mem_dout_a, mem_dout_b,
    input  a_ready, a_rsp_valid, a_rsp_data, b_ready, b_rsp_valid, b_rsp_data,
           mem_we_a, mem_addr_a, mem_din_a, mem_we_b, mem_addr_b, mem_din_b
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata,
           mem_dout_a, mem_dout_b,
    output a_ready, a_rsp_valid, a_rsp_data, b_ready, b_rsp_valid, b_rsp_data,
           mem_we_a, mem_addr_a, mem_din_a, mem_we_b, mem_addr_b, mem_din_b
  );
endinterface

// File: rtl/dpram_rr_arb2.sv
// rtl/dpram_rr_arb2.sv - two-way round-robin arbiter resolving same-bank conflicts
module dpram_rr_arb2
  import dpram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic conflict,
  output logic a_gnt,
  output logic b_gnt
);
  prio_t prio_q, prio_d;

  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= PRIO_A;
    else        prio_q <= prio_d;
  end

  // The loser of a conflict is favoured next time, so neither port starves.
  always_comb begin
    prio_d = prio_q;
    a_gnt  = a_valid;
    b_gnt  = b_valid;
    if (conflict) begin
      if (prio_q == PRIO_A) begin
        b_gnt  = 1'b0;
        prio_d = PRIO_B;
      end else begin
        a_gnt  = 1'b0;
        prio_d = PRIO_A;
      end
    end
  end
endmodule

// File: rtl/dpram_bank_scheduler.sv
// rtl/dpram_bank_scheduler.sv - serialises same-bank A/B requests onto a banked dual-port RAM
// Optional saturating conflict counter port: DPRAM_SCHED_STATS_EN
module dpram_bank_scheduler
  import dpram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  dpram_bank_scheduler_if.slave bus
`ifdef DPRAM_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);
  logic                  conflict, a_gnt, b_gnt;
  mem_req_t              req_a_q, req_b_q;
  logic [1:0]            rd_a_q, rd_b_q;
  logic                  a_rsp_valid_q, b_rsp_valid_q;
  logic [DATA_WIDTH-1:0] a_rsp_data_q, b_rsp_data_q;

  assign conflict = bus.a_valid & bus.b_valid &
                    (bank_of(bus.a_addr) == bank_of(bus.b_addr));

  dpram_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (bus.a_valid),
    .b_valid  (bus.b_valid),
    .conflict (conflict),
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt)
  );

  assign bus.a_ready = a_gnt;
  assign bus.b_ready = b_gnt;

  // rd_x_q tracks reads through issue and the RAM's own output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_a_q       <= '0;
      req_b_q       <= '0;
      rd_a_q        <= '0;
      rd_b_q        <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
    end else begin
      if (a_gnt) req_a_q <= '{we: bus.a_we, addr: bus.a_addr, din: bus.a_wdata};
      else       req_a_q.we <= 1'b0;
      if (b_gnt) req_b_q <= '{we: bus.b_we, addr: bus.b_addr, din: bus.b_wdata};
      else       req_b_q.we <= 1'b0;

      rd_a_q        <= {rd_a_q[0], a_gnt & ~bus.a_we};
      rd_b_q        <= {rd_b_q[0], b_gnt & ~bus.b_we};
      a_rsp_valid_q <= rd_a_q[1];
      b_rsp_valid_q <= rd_b_q[1];
      if (rd_a_q[1]) a_rsp_data_q <= bus.mem_dout_a;
      if (rd_b_q[1]) b_rsp_data_q <= bus.mem_dout_b;
    end
  end

  assign bus.mem_we_a    = req_a_q.we;
  assign bus.mem_addr_a  = req_a_q.addr;
  assign bus.mem_din_a   = req_a_q.din;
  assign bus.mem_we_b    = req_b_q.we;
  assign bus.mem_addr_b  = req_b_q.addr;
  assign bus.mem_din_b   = req_b_q.din;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.a_rsp_data  = a_rsp_data_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.b_rsp_data  = b_rsp_data_q;

`ifdef DPRAM_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                               conflict_cnt <= '0;
    else if (conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
  end
`endif
endmodule

// File: tb/tb_dpram_bank_scheduler.sv
// tb/tb_dpram_bank_scheduler.sv - self-checking bench with table vectors and a reference model
module tb_dpram_bank_scheduler;
  typedef struct packed {
    logic       v;
    logic       we;
    logic [5:0] addr;
    logic [7:0] d;
  } req_t;

  typedef struct {
    req_t a;
    req_t b;
    logic ea;
    logic eb;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] d;
  } rsp_t;

  localparam req_t NONE = '0;

  logic clk = 1'b0;
  logic rst_n;
  dpram_bank_scheduler_if bus();
`ifdef DPRAM_SCHED_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  dpram_bank_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DPRAM_SCHED_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] preload(input int i);
    if (i == 5) return 8'h3C;
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic req_t rq(input logic we, input int addr, input int d);
    req_t r;
    r.v    = 1'b1;
    r.we   = we;
    r.addr = addr[5:0];
    r.d    = d[7:0];
    return r;
  endfunction

  // Behavioural RAM: registered read, write on the clock edge.
  logic [7:0] ram [64];
  bit         ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] = preload(i);
      ram_init = 1'b1;
    end
    bus.mem_dout_a <= ram[bus.mem_addr_a];
    bus.mem_dout_b <= ram[bus.mem_addr_b];
    if (bus.mem_we_a) ram[bus.mem_addr_a] = bus.mem_din_a;
    if (bus.mem_we_b) ram[bus.mem_addr_b] = bus.mem_din_b;
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.a_valid && !bus.a_ready) |=> (bus.a_valid && $stable(bus.a_we) && $stable(bus.a_addr) && $stable(bus.a_wdata)));
  b_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.b_valid && !bus.b_ready) |=> (bus.b_valid && $stable(bus.b_we) && $stable(bus.b_addr) && $stable(bus.b_wdata)));

  int         n_checks = 0;
  int         n_fail = 0;
  int         win = 0;
  logic [7:0] m_mem [64];
  bit         m_prio;
  int         m_cnt;
  rsp_t       qa[$], qb[$];
  logic       exp_we_a, exp_we_b;
  logic [5:0] exp_addr_a, exp_addr_b;
  logic [7:0] exp_din_a, exp_din_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (window %0d)", name, act, exp, win);
    end
  endtask

  task automatic reset_dut(input int n);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    m_prio = 1'b0;
    m_cnt = 0;
    exp_we_a = 1'b0; exp_addr_a = '0; exp_din_a = '0;
    exp_we_b = 1'b0; exp_addr_b = '0; exp_din_b = '0;
    repeat (n) begin
      @(posedge clk); #1; win++;
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_b_ready", bus.b_ready, 0);
      chk("rst_mem_we_a", bus.mem_we_a, 0);
      chk("rst_mem_we_b", bus.mem_we_b, 0);
      chk("rst_mem_addr_a", bus.mem_addr_a, 0);
      chk("rst_mem_addr_b", bus.mem_addr_b, 0);
      chk("rst_mem_din_a", bus.mem_din_a, 0);
      chk("rst_a_rsp_valid", bus.a_rsp_valid, 0);
      chk("rst_b_rsp_valid", bus.b_rsp_valid, 0);
      chk("rst_a_rsp_data", bus.a_rsp_data, 0);
      chk("rst_b_rsp_data", bus.b_rsp_data, 0);
`ifdef DPRAM_SCHED_STATS_EN
      chk("rst_conflict_cnt", conflict_cnt, 0);
`endif
    end
    rst_n = 1'b1;
  endtask

  // One cycle: drive, compare DUT against the model, advance the model.
  task automatic step(input req_t ra, input req_t rb, output logic ga_dut, output logic gb_dut);
    bit conf, ga, gb;
    bus.a_valid = ra.v; bus.a_we = ra.we; bus.a_addr = ra.addr; bus.a_wdata = ra.d;
    bus.b_valid = rb.v; bus.b_we = rb.we; bus.b_addr = rb.addr; bus.b_wdata = rb.d;
    #1;
    conf = ra.v && rb.v && ((ra.addr / 16) == (rb.addr / 16));
    ga = ra.v && !(conf && m_prio);
    gb = rb.v && !(conf && !m_prio);
    chk("a_ready", bus.a_ready, ga);
    chk("b_ready", bus.b_ready, gb);
    chk("mem_we_a", bus.mem_we_a, exp_we_a);
    chk("mem_we_b", bus.mem_we_b, exp_we_b);
    chk("mem_addr_a", bus.mem_addr_a, exp_addr_a);
    chk("mem_addr_b", bus.mem_addr_b, exp_addr_b);
    chk("mem_din_a", bus.mem_din_a, exp_din_a);
    chk("mem_din_b", bus.mem_din_b, exp_din_b);
    if (qa.size() > 0 && qa[0].due == win) begin
      chk("a_rsp_valid", bus.a_rsp_valid, 1);
      chk("a_rsp_data", bus.a_rsp_data, qa[0].d);
      void'(qa.pop_front());
    end else chk("a_rsp_valid_idle", bus.a_rsp_valid, 0);
    if (qb.size() > 0 && qb[0].due == win) begin
      chk("b_rsp_valid", bus.b_rsp_valid, 1);
      chk("b_rsp_data", bus.b_rsp_data, qb[0].d);
      void'(qb.pop_front());
    end else chk("b_rsp_valid_idle", bus.b_rsp_valid, 0);
`ifdef DPRAM_SCHED_STATS_EN
    chk("conflict_cnt", conflict_cnt, m_cnt);
`endif
    if (conf) begin
      m_prio = !m_prio;
      if (m_cnt < 65535) m_cnt++;
    end
    exp_we_a = ga && ra.we;
    exp_we_b = gb && rb.we;
    if (ga) begin exp_addr_a = ra.addr; exp_din_a = ra.d; end
    if (gb) begin exp_addr_b = rb.addr; exp_din_b = rb.d; end
    if (ga && !ra.we) qa.push_back('{due: win + 3, d: m_mem[ra.addr]});
    if (gb && !rb.we) qb.push_back('{due: win + 3, d: m_mem[rb.addr]});
    if (ga && ra.we) m_mem[ra.addr] = ra.d;
    if (gb && rb.we) m_mem[rb.addr] = rb.d;
    ga_dut = bus.a_ready;
    gb_dut = bus.b_ready;
    @(posedge clk); #1; win++;
  endtask

  vec_t tbl [6];
  logic ga, gb;
  req_t pa, pb;
  int   pulses;

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = preload(i);
    tbl[0] = '{a: rq(1, 'h11, 'h11), b: rq(1, 'h12, 'h22), ea: 1'b1, eb: 1'b0};
    tbl[1] = '{a: rq(1, 'h11, 'h11), b: rq(1, 'h12, 'h22), ea: 1'b0, eb: 1'b1};
    tbl[2] = '{a: rq(1, 'h11, 'h11), b: rq(1, 'h12, 'h22), ea: 1'b1, eb: 1'b0};
    tbl[3] = '{a: NONE,              b: rq(1, 'h12, 'h22), ea: 1'b0, eb: 1'b1};
    tbl[4] = '{a: rq(0, 'h05, 0),    b: rq(0, 'h25, 0),    ea: 1'b1, eb: 1'b1};
    tbl[5] = '{a: NONE,              b: NONE,              ea: 1'b0, eb: 1'b0};

    rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    @(posedge clk); #1;
    reset_dut(2);

    // Single read on A
    step(rq(0, 'h05, 0), NONE, ga, gb);
    chk("t1_a_ready", ga, 1);
    chk("t1_mem_addr_a", bus.mem_addr_a, 'h05);
    step(NONE, NONE, ga, gb);
    step(NONE, NONE, ga, gb);
    chk("t1_a_rsp_valid", bus.a_rsp_valid, 1);
    chk("t1_a_rsp_data", bus.a_rsp_data, 'h3C);
    chk("t1_b_rsp_valid", bus.b_rsp_valid, 0);

    // Different banks issue together
    step(rq(1, 'h10, 'hAA), rq(0, 'h25, 0), ga, gb);
    chk("t2_both_ready", {ga, gb}, 2'b11);
    chk("t2_mem_we_a", bus.mem_we_a, 1);
    chk("t2_mem_we_b", bus.mem_we_b, 0);
    step(NONE, NONE, ga, gb);
    step(NONE, NONE, ga, gb);
    chk("t2_b_rsp_data", bus.b_rsp_data, preload('h25));

    // Same-address write race, then read back
    step(rq(1, 'h30, 'h55), rq(1, 'h30, 'h66), ga, gb);
    chk("t3_race_first", {ga, gb}, 2'b10);
    step(NONE, rq(1, 'h30, 'h66), ga, gb);
    chk("t3_race_second", gb, 1);
    step(rq(0, 'h30, 0), NONE, ga, gb);
    step(NONE, NONE, ga, gb);
    step(NONE, NONE, ga, gb);
    chk("t3_readback", bus.a_rsp_data, 'h66);

    // Read right after write, then a back-to-back read burst
    step(rq(1, 'h08, 'h77), NONE, ga, gb);
    step(rq(0, 'h08, 0), NONE, ga, gb);
    step(NONE, NONE, ga, gb);
    step(NONE, NONE, ga, gb);
    chk("t4_raw_data", bus.a_rsp_data, 'h77);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(NONE, rq(0, 'h20 + i, 0), ga, gb);
      pulses += int'(bus.b_rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(NONE, NONE, ga, gb);
      pulses += int'(bus.b_rsp_valid);
    end
    chk("t4_burst_pulses", pulses, 8);

    // Conflict table
    reset_dut(1);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].a, tbl[i].b, ga, gb);
      chk($sformatf("tbl%0d_a_ready", i), ga, tbl[i].ea);
      chk($sformatf("tbl%0d_b_ready", i), gb, tbl[i].eb);
    end
`ifdef DPRAM_SCHED_STATS_EN
    chk("t5_conflict_cnt", conflict_cnt, 3);
`endif

    // Reset one cycle after accepting a read
    step(rq(0, 'h05, 0), rq(1, 'h2F, 'h99), ga, gb);
    chk("t6_mem_we_b_before", bus.mem_we_b, 1);
    reset_dut(2);
    step(rq(1, 'h01, 'h01), rq(1, 'h02, 'h02), ga, gb);
    chk("t6_prio_after_reset", {ga, gb}, 2'b10);
    step(NONE, rq(1, 'h02, 'h02), ga, gb);

    // Randomised traffic against the model
    pa = NONE;
    pb = NONE;
    for (int c = 0; c < 400; c++) begin
      if (!pa.v && $urandom_range(0, 2) != 0)
        pa = rq(1'($urandom_range(0, 1)), $urandom_range(0, 3) * 16 + $urandom_range(0, 3), $urandom_range(0, 255));
      if (!pb.v && $urandom_range(0, 2) != 0)
        pb = rq(1'($urandom_range(0, 1)), $urandom_range(0, 3) * 16 + $urandom_range(0, 3), $urandom_range(0, 255));
      step(pa, pb, ga, gb);
      if (ga) pa.v = 1'b0;
      if (gb) pb.v = 1'b0;
    end
    for (int i = 0; i < 10 && (pa.v || pb.v); i++) begin
      step(pa, pb, ga, gb);
      if (ga) pa.v = 1'b0;
      if (gb) pb.v = 1'b0;
    end
    chk("drain_done", {pa.v, pb.v}, 2'b00);
    for (int i = 0; i < 4; i++) step(NONE, NONE, ga, gb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
